branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- Companion to the branch prediction unit at the resolution end of the prediction/update protocol.
- Fetch pushes each predicted branch (PC, predicted direction, predicted target) in program order. Execute later reports actual outcomes in the same order.
- The block checks each outcome against the stored prediction, drives the predictor update port (branch/taken/pc/target), and raises a flush plus redirect PC on a mispredict.

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of two, at least 4.
- PC_W, 9, program-counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- push1  input  1  older fetched branch valid.
- push2  input  1  younger fetched branch valid; ignored unless push1.
- pushPc1, pushPc2  input  PC_W  branch PCs.
- pushPred1, pushPred2  input  1  predicted taken.
- pushTarget1, pushTarget2  input  PC_W  predicted target.
- full  output  1  fewer than 2 free entries.
- count  output  $clog2(DEPTH)+1  occupied entries.
- res1  input  1  older resolution valid.
- res2  input  1  younger resolution valid; ignored unless res1.
- resTaken1, resTaken2  input  1  actual direction.
- resTarget1, resTarget2  input  PC_W  actual target.
- upd1, upd2  output  1  predictor update strobes (to branch1/branch2).
- updTaken1, updTaken2  output  1  actual direction to predictor.
- updPc1, updPc2  output  PC_W  PC of the updated branch.
- updTarget1, updTarget2  output  PC_W  actual target.
- flush  output  1  one-cycle mispredict pulse.
- redirectPC  output  PC_W  correct fetch PC, valid with flush.

Behaviour:
- Reset (synchronous, highest priority): head=tail=0, count=0, full=0. All upd*, updTaken*, flush = 0. updPc*, updTarget*, redirectPC = 0. Reset overrides any same-cycle push or resolve.
- Storage: circular buffer, head/tail wrap modulo DEPTH. push1 writes at tail, push2 at tail+1. A push cycle is accepted only when full=0; when full=1 it is dropped entirely, with no partial accept.
- Resolve: res1 pops head and res2 pops head+1. A resolve with insufficient entries is ignored per missing entry: res2 ignored if count<2, both ignored if count=0.
- Mispredict condition: predTaken != resTaken, or both taken and predTarget != resTarget.
- Outputs are registered, one cycle after res.
  - updN = 1 for each processed entry.
  - updPcN and updTargetN come from the entry / res inputs.
- If entry 1 mispredicts:
  - res2 is discarded: upd2 = 0 and entry 2 is not popped separately.
  - Whole queue is cleared: head=tail, count=0.
  - Same-cycle pushes are discarded.
  - flush=1 next cycle. redirectPC = resTarget1 if resTaken1, else pc1+1.
- If only entry 2 mispredicts: same clear/discard behaviour, with redirect from entry 2.
- PC+1 wraps modulo 2^PC_W (511 -> 0).
- flush lasts one cycle and is never asserted two consecutive cycles from a single event.
- Simultaneous push and resolve without mispredict: count_next = count + pushes - pops. full and count are updated the same edge.

Optional Feature:
- Macro BRQ_STATS_EN. When defined, add ports statResolved (output, 16) and statMispred (output, 16).
  - statResolved counts processed entries, +0..2 per cycle.
  - statMispred counts mispredict events, +1 per flush.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push1 pc=0x010 pred=1 tgt=0x040; next cycle res1 taken tgt=0x040 -> next cycle upd1=1, updPc1=0x010, updTaken1=1, updTarget1=0x040, flush=0, count=0.
- Push pc=0x020 pred=0; res1 taken tgt=0x080 -> flush=1 one cycle, redirectPC=0x080, count=0, updTaken1=1.
- Push pc=0x1FF pred=1 tgt=0x005; res1 not taken -> flush=1, redirectPC=0x000 (wrap).
- Push two entries pc 0x030 and 0x031, both pred=0; res1+res2 where res1 is mispredicted taken to 0x050 -> upd1=1, upd2=0, redirectPC=0x050, queue empty.
- Fill to DEPTH-1 -> full=1; push1 -> ignored, count unchanged. Then push2 with res1 correct the same cycle -> still full=1, push dropped, count decrements by 1.
- Assert reset with 3 entries queued plus same-cycle res1 -> count=0, upd1=0, flush=0 next cycle. With BRQ_STATS_EN, counters read 0.

Source files
------------

// File: rtl/branch_resolve_queue_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue_if
//   Bundles the fetch push port, the execute resolve port and the predictor
//   update / redirect outputs of branch_resolve_queue.
//   master : fetch/execute side (drives push*/res*, observes the rest)
//   slave  : the queue itself
// Signals:
//   push1/push2, pushPc*, pushPred*, pushTarget*   fetched predicted branches
//   full, count                                     occupancy status
//   res1/res2, resTaken*, resTarget*                actual outcomes, in order
//   upd*, updTaken*, updPc*, updTarget*             predictor update port
//   flush, redirectPC                               mispredict recovery
// ---------------------------------------------------------------------------
interface branch_resolve_queue_if #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 9
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              push1;
    logic              push2;
    logic [PC_W-1:0]   pushPc1;
    logic [PC_W-1:0]   pushPc2;
    logic              pushPred1;
    logic              pushPred2;
    logic [PC_W-1:0]   pushTarget1;
    logic [PC_W-1:0]   pushTarget2;
    logic              full;
    logic [CNT_W-1:0]  count;

    logic              res1;
    logic              res2;
    logic              resTaken1;
    logic              resTaken2;
    logic [PC_W-1:0]   resTarget1;
    logic [PC_W-1:0]   resTarget2;

    logic              upd1;
    logic              upd2;
    logic              updTaken1;
    logic              updTaken2;
    logic [PC_W-1:0]   updPc1;
    logic [PC_W-1:0]   updPc2;
    logic [PC_W-1:0]   updTarget1;
    logic [PC_W-1:0]   updTarget2;
    logic              flush;
    logic [PC_W-1:0]   redirectPC;

    modport master (
        output push1, push2, pushPc1, pushPc2, pushPred1, pushPred2,
               pushTarget1, pushTarget2,
               res1, res2, resTaken1, resTaken2, resTarget1, resTarget2,
        input  full, count,
               upd1, upd2, updTaken1, updTaken2, updPc1, updPc2,
               updTarget1, updTarget2, flush, redirectPC
    );

    modport slave (
        input  push1, push2, pushPc1, pushPc2, pushPred1, pushPred2,
               pushTarget1, pushTarget2,
               res1, res2, resTaken1, resTaken2, resTarget1, resTarget2,
        output full, count,
               upd1, upd2, updTaken1, updTaken2, updPc1, updPc2,
               updTarget1, updTarget2, flush, redirectPC
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue
//   In-order queue of predicted branches. Fetch pushes up to two predictions
//   per cycle; execute resolves up to two per cycle in the same order. Each
//   resolved entry is compared with its prediction, the predictor is updated,
//   and a mispredict clears the queue and pulses flush with the correct PC.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   brq    branch_resolve_queue_if.slave (push, resolve, update, redirect)
//   statResolved / statMispred (16 bit, saturating) exist only when the
//   macro BRQ_STATS_EN is defined.
// Parameters:
//   DEPTH  in-flight entries, power of two, >= 4
//   PC_W   program-counter width
// ---------------------------------------------------------------------------
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_resolve_queue_if.slave  brq
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]            statResolved,
    output logic [15:0]            statMispred
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
        logic [PC_W-1:0] target;
    } entry_t;

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] head_p1, tail_p1;

    entry_t slot_w [DEPTH];
    entry_t ent1, ent2, push_ent1, push_ent2;

    logic full_w;
    logic push_ok, push_two;
    logic do1, do2, do2_keep;
    logic mis1, mis2, mis_any;
    logic wr1, wr2;
    logic [1:0] n_push, n_pop;

    logic            upd1_reg, upd2_reg;
    logic            upd_taken1_reg, upd_taken2_reg;
    logic [PC_W-1:0] upd_pc1_reg, upd_pc2_reg;
    logic [PC_W-1:0] upd_target1_reg, upd_target2_reg;
    logic            flush_reg;
    logic [PC_W-1:0] redirect_pc_reg;

    function automatic logic mispredicts(input entry_t e, input logic taken,
                                         input logic [PC_W-1:0] tgt);
        return (e.pred != taken) || (taken && e.pred && (e.target != tgt));
    endfunction

    assign head_p1 = head_reg + PTR_W'(1);
    assign tail_p1 = tail_reg + PTR_W'(1);

    // Fewer than two free slots: a push cycle may carry two entries, so the
    // whole cycle is refused rather than partially accepted.
    assign full_w = count_reg > CNT_W'(DEPTH - 2);

    assign push_ok  = brq.push1 && !full_w;
    assign push_two = push_ok && brq.push2;

    // Resolves only consume entries that were present at the start of the cycle.
    assign do1 = brq.res1 && (count_reg != '0);
    assign do2 = brq.res1 && brq.res2 && (count_reg > CNT_W'(1));

    assign ent1 = slot_w[head_reg];
    assign ent2 = slot_w[head_p1];

    assign mis1     = do1 && mispredicts(ent1, brq.resTaken1, brq.resTarget1);
    // A mispredict on the older branch makes the younger one wrong-path.
    assign do2_keep = do2 && !mis1;
    assign mis2     = do2_keep && mispredicts(ent2, brq.resTaken2, brq.resTarget2);
    assign mis_any  = mis1 || mis2;

    assign push_ent1 = '{pc: brq.pushPc1, pred: brq.pushPred1, target: brq.pushTarget1};
    assign push_ent2 = '{pc: brq.pushPc2, pred: brq.pushPred2, target: brq.pushTarget2};

    assign wr1 = push_ok && !mis_any;
    assign wr2 = push_two && !mis_any;

    // Per-slot storage; write port 1 lands on tail, port 2 on tail+1.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            entry_t slot_reg;
            always_ff @(posedge clk) begin
                if (wr1 && (tail_reg == PTR_W'(gi))) begin
                    slot_reg <= push_ent1;
                end else if (wr2 && (tail_p1 == PTR_W'(gi))) begin
                    slot_reg <= push_ent2;
                end
            end
            assign slot_w[gi] = slot_reg;
        end
    endgenerate

    always_comb begin
        n_push     = 2'd0;
        n_pop      = 2'd0;
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (push_two) begin
            n_push = 2'd2;
        end else if (push_ok) begin
            n_push = 2'd1;
        end
        if (do2) begin
            n_pop = 2'd2;
        end else if (do1) begin
            n_pop = 2'd1;
        end
        if (mis_any) begin
            // Everything younger than the mispredict is wrong-path: drop it all.
            head_next  = tail_reg;
            count_next = '0;
        end else begin
            head_next  = head_reg + PTR_W'(n_pop);
            tail_next  = tail_reg + PTR_W'(n_push);
            count_next = count_reg + CNT_W'(n_push) - CNT_W'(n_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            upd1_reg        <= 1'b0;
            upd2_reg        <= 1'b0;
            upd_taken1_reg  <= 1'b0;
            upd_taken2_reg  <= 1'b0;
            upd_pc1_reg     <= '0;
            upd_pc2_reg     <= '0;
            upd_target1_reg <= '0;
            upd_target2_reg <= '0;
            flush_reg       <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            upd1_reg  <= do1;
            upd2_reg  <= do2_keep;
            flush_reg <= mis_any;
            if (do1) begin
                upd_pc1_reg     <= ent1.pc;
                upd_taken1_reg  <= brq.resTaken1;
                upd_target1_reg <= brq.resTarget1;
            end
            if (do2_keep) begin
                upd_pc2_reg     <= ent2.pc;
                upd_taken2_reg  <= brq.resTaken2;
                upd_target2_reg <= brq.resTarget2;
            end
            // Fall-through PC wraps naturally at PC_W bits.
            if (mis1) begin
                redirect_pc_reg <= brq.resTaken1 ? brq.resTarget1 : ent1.pc + PC_W'(1);
            end else if (mis2) begin
                redirect_pc_reg <= brq.resTaken2 ? brq.resTarget2 : ent2.pc + PC_W'(1);
            end
        end
    end

    assign brq.full       = full_w;
    assign brq.count      = count_reg;
    assign brq.upd1       = upd1_reg;
    assign brq.upd2       = upd2_reg;
    assign brq.updTaken1  = upd_taken1_reg;
    assign brq.updTaken2  = upd_taken2_reg;
    assign brq.updPc1     = upd_pc1_reg;
    assign brq.updPc2     = upd_pc2_reg;
    assign brq.updTarget1 = upd_target1_reg;
    assign brq.updTarget2 = upd_target2_reg;
    assign brq.flush      = flush_reg;
    assign brq.redirectPC = redirect_pc_reg;

`ifdef BRQ_STATS_EN
    logic [15:0] stat_resolved_reg, stat_mispred_reg;
    logic [1:0]  n_resolved;
    logic [16:0] resolved_sum;

    assign n_resolved   = {1'b0, do1} + {1'b0, do2_keep};
    assign resolved_sum = {1'b0, stat_resolved_reg} + 17'(n_resolved);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_resolved_reg <= '0;
            stat_mispred_reg  <= '0;
        end else begin
            stat_resolved_reg <= resolved_sum[16] ? 16'hFFFF : resolved_sum[15:0];
            if (mis_any && (stat_mispred_reg != 16'hFFFF)) begin
                stat_mispred_reg <= stat_mispred_reg + 16'd1;
            end
        end
    end

    assign statResolved = stat_resolved_reg;
    assign statMispred  = stat_mispred_reg;
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_queue
//   Directed, table-driven checks of branch_resolve_queue (DEPTH=8, PC_W=9)
//   plus hand-written reset sequences. Define BRQ_STATS_EN to also cover the
//   statistics counters.
// ---------------------------------------------------------------------------
module tb_branch_resolve_queue;
    localparam int DEPTH = 8;
    localparam int PC_W  = 9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bif ();

`ifdef BRQ_STATS_EN
    logic [15:0] stat_resolved, stat_mispred;
`endif

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .brq   (bif)
`ifdef BRQ_STATS_EN
        ,
        .statResolved (stat_resolved),
        .statMispred  (stat_mispred)
`endif
    );

    typedef struct {
        string      name;
        logic       p1, p2, pr1, pr2;
        logic [8:0] pc1, pc2, pt1, pt2;
        logic       r1, r2, rt1, rt2;
        logic [8:0] rg1, rg2;
        logic [3:0] e_count;
        logic       e_full, e_flush;
        logic [8:0] e_redir;
        logic       e_u1, e_tk1, e_u2, e_tk2;
        logic [8:0] e_pc1, e_tg1, e_pc2, e_tg2;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t vp(input string n, input logic p1, input logic [8:0] pc1,
                                input logic pr1, input logic [8:0] pt1, input logic p2,
                                input logic [8:0] pc2, input logic pr2, input logic [8:0] pt2);
        vec_t v;
        v.name = n;
        v.p1 = p1; v.pc1 = pc1; v.pr1 = pr1; v.pt1 = pt1;
        v.p2 = p2; v.pc2 = pc2; v.pr2 = pr2; v.pt2 = pt2;
        v.r1 = 0; v.r2 = 0; v.rt1 = 0; v.rt2 = 0; v.rg1 = 0; v.rg2 = 0;
        v.e_count = 0; v.e_full = 0; v.e_flush = 0; v.e_redir = 0;
        v.e_u1 = 0; v.e_tk1 = 0; v.e_pc1 = 0; v.e_tg1 = 0;
        v.e_u2 = 0; v.e_tk2 = 0; v.e_pc2 = 0; v.e_tg2 = 0;
        return v;
    endfunction

    function automatic vec_t vr(input vec_t vin, input logic r1, input logic rt1,
                                input logic [8:0] rg1, input logic r2, input logic rt2,
                                input logic [8:0] rg2);
        vec_t v = vin;
        v.r1 = r1; v.rt1 = rt1; v.rg1 = rg1;
        v.r2 = r2; v.rt2 = rt2; v.rg2 = rg2;
        return v;
    endfunction

    function automatic vec_t ve(input vec_t vin, input logic [3:0] cnt, input logic full,
                                input logic flush, input logic [8:0] redir,
                                input logic u1, input logic tk1, input logic [8:0] pc1,
                                input logic [8:0] tg1, input logic u2, input logic tk2,
                                input logic [8:0] pc2, input logic [8:0] tg2);
        vec_t v = vin;
        v.e_count = cnt; v.e_full = full; v.e_flush = flush; v.e_redir = redir;
        v.e_u1 = u1; v.e_tk1 = tk1; v.e_pc1 = pc1; v.e_tg1 = tg1;
        v.e_u2 = u2; v.e_tk2 = tk2; v.e_pc2 = pc2; v.e_tg2 = tg2;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bif.push1 = v.p1; bif.pushPc1 = v.pc1; bif.pushPred1 = v.pr1; bif.pushTarget1 = v.pt1;
        bif.push2 = v.p2; bif.pushPc2 = v.pc2; bif.pushPred2 = v.pr2; bif.pushTarget2 = v.pt2;
        bif.res1 = v.r1; bif.resTaken1 = v.rt1; bif.resTarget1 = v.rg1;
        bif.res2 = v.r2; bif.resTaken2 = v.rt2; bif.resTarget2 = v.rg2;
    endtask

    initial begin
        vec_t v;
        vec_t idle;
        idle = vp("idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // name / pushes                        res                      expectations after the edge
        vecs.push_back(ve(vp("push_010", 1, 9'h010, 1, 9'h040, 0, 0, 0, 0),
                          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vr(vp("res_ok_010", 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 9'h040, 0, 0, 0),
                          0, 0, 0, 0, 1, 1, 9'h010, 9'h040, 0, 0, 0, 0));
        vecs.push_back(ve(vp("push_020", 1, 9'h020, 0, 9'h021, 0, 0, 0, 0),
                          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vr(vp("mis_dir_020", 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 9'h080, 0, 0, 0),
                          0, 0, 1, 9'h080, 1, 1, 9'h020, 9'h080, 0, 0, 0, 0));
        vecs.push_back(ve(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vp("push_1ff", 1, 9'h1FF, 1, 9'h005, 0, 0, 0, 0),
                          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vr(vp("mis_wrap_1ff", 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 9'h100, 0, 0, 0),
                          0, 0, 1, 9'h000, 1, 0, 9'h1FF, 9'h100, 0, 0, 0, 0));
        vecs.push_back(ve(vp("push_030_031", 1, 9'h030, 0, 0, 1, 9'h031, 0, 0),
                          2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vr(vp("mis1_drop2", 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 9'h050, 1, 0, 9'h033),
                          0, 0, 1, 9'h050, 1, 1, 9'h030, 9'h050, 0, 0, 0, 0));
        vecs.push_back(ve(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vp("push_100_101", 1, 9'h100, 1, 9'h120, 1, 9'h101, 0, 9'h000),
                          2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vr(vp("res2_ok_push", 1, 9'h102, 1, 9'h140, 0, 0, 0, 0), 1, 1, 9'h120, 1, 0, 9'h0AB),
                          1, 0, 0, 0, 1, 1, 9'h100, 9'h120, 1, 0, 9'h101, 9'h0AB));
        vecs.push_back(ve(vp("push_103", 1, 9'h103, 1, 9'h150, 0, 0, 0, 0),
                          2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vr(vp("mis2_tgt", 1, 9'h104, 0, 0, 0, 0, 0, 0), 1, 1, 9'h140, 1, 1, 9'h155),
                          0, 0, 1, 9'h155, 1, 1, 9'h102, 9'h140, 1, 1, 9'h103, 9'h155));
        vecs.push_back(ve(vr(vp("res_empty", 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 9'h011, 1, 1, 9'h022),
                          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vp("push_0a0", 1, 9'h0A0, 0, 9'h000, 0, 0, 0, 0),
                          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vr(vp("res2_short", 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 9'h1AA, 1, 1, 9'h0BB),
                          0, 0, 0, 0, 1, 0, 9'h0A0, 9'h1AA, 0, 0, 0, 0));
        // Fill to DEPTH-1, then confirm pushes are refused while full.
        vecs.push_back(ve(vp("fill_2", 1, 9'h001, 0, 0, 1, 9'h002, 0, 0),
                          2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vp("fill_4", 1, 9'h003, 0, 0, 1, 9'h004, 0, 0),
                          4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vp("fill_6", 1, 9'h005, 0, 0, 1, 9'h006, 0, 0),
                          6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vp("fill_7", 1, 9'h007, 0, 0, 0, 0, 0, 0),
                          7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vp("full_drop", 1, 9'h008, 0, 0, 0, 0, 0, 0),
                          7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(ve(vr(vp("full_drop_res", 1, 9'h009, 0, 0, 1, 9'h00A, 0, 0), 1, 0, 9'h000, 0, 0, 0),
                          6, 0, 0, 0, 1, 0, 9'h001, 9'h000, 0, 0, 0, 0));
        vecs.push_back(ve(vr(vp("drain_a", 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 9'h000, 1, 0, 9'h000),
                          4, 0, 0, 0, 1, 0, 9'h002, 9'h000, 1, 0, 9'h003, 9'h000));
        vecs.push_back(ve(vr(vp("drain_b", 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 9'h000, 1, 0, 9'h000),
                          2, 0, 0, 0, 1, 0, 9'h004, 9'h000, 1, 0, 9'h005, 9'h000));
        vecs.push_back(ve(vr(vp("drain_c", 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 9'h000, 1, 0, 9'h000),
                          0, 0, 0, 0, 1, 0, 9'h006, 9'h000, 1, 0, 9'h007, 9'h000));

        // Reset state
        reset = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(bif.count), 32'd0);
        chk("rst_full", 32'(bif.full), 32'd0);
        chk("rst_upd1", 32'(bif.upd1), 32'd0);
        chk("rst_upd2", 32'(bif.upd2), 32'd0);
        chk("rst_flush", 32'(bif.flush), 32'd0);
        chk("rst_redirect", 32'(bif.redirectPC), 32'd0);
        chk("rst_updpc1", 32'(bif.updPc1), 32'd0);
        chk("rst_updtgt2", 32'(bif.updTarget2), 32'd0);
        $display("txn reset count=%0d flush=%0d", bif.count, bif.flush);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v);
            @(posedge clk);
            #1;
            chk({v.name, ".count"}, 32'(bif.count), 32'(v.e_count));
            chk({v.name, ".full"}, 32'(bif.full), 32'(v.e_full));
            chk({v.name, ".flush"}, 32'(bif.flush), 32'(v.e_flush));
            chk({v.name, ".upd1"}, 32'(bif.upd1), 32'(v.e_u1));
            chk({v.name, ".upd2"}, 32'(bif.upd2), 32'(v.e_u2));
            if (v.e_u1) begin
                chk({v.name, ".updPc1"}, 32'(bif.updPc1), 32'(v.e_pc1));
                chk({v.name, ".updTaken1"}, 32'(bif.updTaken1), 32'(v.e_tk1));
                chk({v.name, ".updTarget1"}, 32'(bif.updTarget1), 32'(v.e_tg1));
            end
            if (v.e_u2) begin
                chk({v.name, ".updPc2"}, 32'(bif.updPc2), 32'(v.e_pc2));
                chk({v.name, ".updTaken2"}, 32'(bif.updTaken2), 32'(v.e_tk2));
                chk({v.name, ".updTarget2"}, 32'(bif.updTarget2), 32'(v.e_tg2));
            end
            if (v.e_flush) begin
                chk({v.name, ".redirectPC"}, 32'(bif.redirectPC), 32'(v.e_redir));
            end
            $display("txn %0d %s count=%0d full=%0d upd1=%0d upd2=%0d flush=%0d redirect=0x%03h",
                     i, v.name, bif.count, bif.full, bif.upd1, bif.upd2, bif.flush, bif.redirectPC);
        end
        drive(idle);

`ifdef BRQ_STATS_EN
        // 16 processed entries and 4 mispredicts across the table above.
        chk("stat_resolved", 32'(stat_resolved), 32'd16);
        chk("stat_mispred", 32'(stat_mispred), 32'd4);
`endif

        // Reset with three entries queued and a same-cycle resolve and push.
        v = vp("q3_a", 1, 9'h011, 1, 9'h060, 1, 9'h012, 0, 0);
        drive(v);
        @(posedge clk);
        #1;
        v = vp("q3_b", 1, 9'h013, 1, 9'h070, 0, 0, 0, 0);
        drive(v);
        @(posedge clk);
        #1;
        chk("q3_count", 32'(bif.count), 32'd3);
        $display("txn queue3 count=%0d", bif.count);
        v = vr(vp("rst_res", 1, 9'h014, 0, 0, 0, 0, 0, 0), 1, 1, 9'h020, 0, 0, 0);
        drive(v);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstq_count", 32'(bif.count), 32'd0);
        chk("rstq_upd1", 32'(bif.upd1), 32'd0);
        chk("rstq_flush", 32'(bif.flush), 32'd0);
        chk("rstq_full", 32'(bif.full), 32'd0);
`ifdef BRQ_STATS_EN
        chk("rstq_stat_resolved", 32'(stat_resolved), 32'd0);
        chk("rstq_stat_mispred", 32'(stat_mispred), 32'd0);
`endif
        $display("txn reset_busy count=%0d upd1=%0d flush=%0d", bif.count, bif.upd1, bif.flush);
        reset = 1'b0;

        // Queue is usable straight after reset; the stale entries are gone.
        v = vr(vp("post_rst", 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 9'h020, 0, 0, 0);
        drive(v);
        @(posedge clk);
        #1;
        chk("post_rst_upd1", 32'(bif.upd1), 32'd0);
        chk("post_rst_count", 32'(bif.count), 32'd0);
        drive(vp("post_push", 1, 9'h0C0, 1, 9'h0C8, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("post_push_count", 32'(bif.count), 32'd1);
        drive(vr(vp("post_res", 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 9'h0C8, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("post_res_upd1", 32'(bif.upd1), 32'd1);
        chk("post_res_updPc1", 32'(bif.updPc1), 32'h0C0);
        chk("post_res_flush", 32'(bif.flush), 32'd0);
        $display("txn post_reset count=%0d upd1=%0d pc=0x%03h", bif.count, bif.upd1, bif.updPc1);
        drive(idle);
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
